// File: rtl/rv_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : rv_dmem_responder
//  Description : Single-port data-memory responder for a RISC-V style
//                load/store initiator. A request is accepted in IDLE and
//                acknowledged with a one-cycle Address_rsp. A write then waits
//                for WData_vld. A read waits a fixed LATENCY. Both complete
//                with a one-cycle Data_rsp. Illegal size, misaligned and
//                out-of-range accesses finish the full handshake with Err=1.
//                A write that raises Err leaves the array unchanged. A read
//                that raises Err returns zero.
//  Ports       : clk, rst          - clock (rising edge), sync active-high reset
//                Address_vld/Address/MemOp/MemOpSize - request (sampled in IDLE)
//                Address_rsp       - request accepted pulse
//                WData_vld/WriteData - write data phase (sampled in WAIT_WDATA)
//                ReadData/Data_rsp/Err - data phase completion
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Address_vld,
    input  logic [31:0] Address,
    input  logic        MemOp,
    input  logic [1:0]  MemOpSize,
    output logic        Address_rsp,
    input  logic        WData_vld,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Data_rsp,
    output logic        Err
);

    localparam int         AW           = $clog2(DEPTH_WORDS);
    localparam logic [3:0] C_LAT_LAST   = 4'(LATENCY - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ACK        = 3'd1;
    localparam logic [2:0] S_WAIT_WDATA = 3'd2;
    localparam logic [2:0] S_WAIT_LAT   = 3'd3;
    localparam logic [2:0] S_RESP       = 3'd4;

    localparam logic [1:0] C_SZ_BYTE    = 2'd0;
    localparam logic [1:0] C_SZ_HALF    = 2'd1;
    localparam logic [1:0] C_SZ_WORD    = 2'd2;

    logic [2:0]  r_state_q, w_state_d;
    logic [3:0]  r_lat_q, w_lat_d;
    logic [31:0] r_addr_q;
    logic        r_op_q;
    logic [1:0]  r_size_q;
    logic [31:0] r_rdata_q;
    logic [31:0] r_mem_q [DEPTH_WORDS];

    logic        w_err;
    logic        w_wr_commit;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rd_ext;
    logic [AW-1:0] w_idx;

    assign w_idx = r_addr_q[AW+1:2];

    // Error classification works only on the captured request, so inputs
    // that change after acceptance cannot affect the outcome.
    always_comb begin
        w_err = 1'b0;
        if (r_size_q == 2'd3)
            w_err = 1'b1;
        if (r_size_q == C_SZ_HALF && r_addr_q[0])
            w_err = 1'b1;
        if (r_size_q == C_SZ_WORD && r_addr_q[1:0] != 2'b00)
            w_err = 1'b1;
        if ({2'b00, r_addr_q[31:2]} >= 32'(DEPTH_WORDS))
            w_err = 1'b1;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_lat_q   <= 4'd0;
        end else begin
            r_state_q <= w_state_d;
            r_lat_q   <= w_lat_d;
        end
    end

    // Request capture: only an accepting IDLE cycle loads the registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_q <= 32'd0;
            r_op_q   <= 1'b0;
            r_size_q <= 2'd0;
        end else if (r_state_q == S_IDLE && Address_vld) begin
            r_addr_q <= Address;
            r_op_q   <= MemOp;
            r_size_q <= MemOpSize;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_lat_d   = 4'd0;
        case (r_state_q)
            S_IDLE: begin
                if (Address_vld)
                    w_state_d = S_ACK;
            end
            S_ACK: begin
                if (r_op_q) begin
                    w_state_d = S_WAIT_WDATA;
                end else if (LATENCY > 1) begin
                    // Counter starts at 1 so WAIT_LAT lasts LATENCY-1 cycles.
                    w_state_d = S_WAIT_LAT;
                    w_lat_d   = 4'd1;
                end else begin
                    // Data_rsp must follow Address_rsp directly; there are
                    // no latency cycles left to count.
                    w_state_d = S_RESP;
                end
            end
            S_WAIT_WDATA: begin
                if (WData_vld)
                    w_state_d = S_RESP;
            end
            S_WAIT_LAT: begin
                if (r_lat_q == C_LAT_LAST)
                    w_state_d = S_RESP;
                else
                    w_lat_d = r_lat_q + 4'd1;
            end
            S_RESP: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write lane steering
    // ------------------------------------------------------------------
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = WriteData;
        case (r_size_q)
            C_SZ_BYTE: begin
                w_be    = 4'b0001 << r_addr_q[1:0];
                w_wdata = {4{WriteData[7:0]}};
            end
            C_SZ_HALF: begin
                w_be    = r_addr_q[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{WriteData[15:0]}};
            end
            C_SZ_WORD: begin
                w_be    = 4'b1111;
            end
            default: begin
                w_be    = 4'b0000;
            end
        endcase
    end

    // A reset on the commit edge wins over the write.
    assign w_wr_commit = (r_state_q == S_WAIT_WDATA) && WData_vld && !w_err && !rst;

    // Array: no reset so contents survive rst. The read port is registered
    // every cycle from the captured index; it is valid by the first cycle
    // after ACK, which is the earliest possible RESP for a read.
    always_ff @(posedge clk) begin
        if (w_wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem_q[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
        r_rdata_q <= r_mem_q[w_idx];
    end

    // Read extraction, right-justified and zero-extended.
    always_comb begin
        w_rd_ext = r_rdata_q;
        case (r_size_q)
            C_SZ_BYTE: w_rd_ext = {24'd0, r_rdata_q[8*r_addr_q[1:0] +: 8]};
            C_SZ_HALF: w_rd_ext = {16'd0, r_rdata_q[16*r_addr_q[1] +: 16]};
            default:   w_rd_ext = r_rdata_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        Address_rsp = 1'b0;
        Data_rsp    = 1'b0;
        Err         = 1'b0;
        ReadData    = 32'd0;
        case (r_state_q)
            S_ACK: begin
                Address_rsp = 1'b1;
            end
            S_RESP: begin
                Data_rsp = 1'b1;
                Err      = w_err;
                if (!r_op_q && !w_err)
                    ReadData = w_rd_ext;
            end
            default: begin
                Address_rsp = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv_dmem_responder
//  Description : Bench for rv_dmem_responder. Instance A uses LATENCY=1 and
//                1024 words. Instance B uses LATENCY=4 and 64 words. The two
//                instances share the request buses, and sel gates each valid.
//                The reference model is a byte-addressed array.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        sel;
    logic        vld, memop, wvld;
    logic [1:0]  size;
    logic [31:0] addr, wdata;

    logic        a_arsp, a_drsp, a_err, b_arsp, b_drsp, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        arsp, drsp, err;
    logic [31:0] rdata;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    logic [7:0] mem_a [4096];
    logic [7:0] mem_b [256];

    always #5 clk = ~clk;

    rv_dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut_a (
        .clk        (clk),
        .rst        (rst_a),
        .Address_vld(vld & ~sel),
        .Address    (addr),
        .MemOp      (memop),
        .MemOpSize  (size),
        .Address_rsp(a_arsp),
        .WData_vld  (wvld & ~sel),
        .WriteData  (wdata),
        .ReadData   (a_rdata),
        .Data_rsp   (a_drsp),
        .Err        (a_err)
    );

    rv_dmem_responder #(.DEPTH_WORDS(64), .LATENCY(4)) u_dut_b (
        .clk        (clk),
        .rst        (rst_b),
        .Address_vld(vld & sel),
        .Address    (addr),
        .MemOp      (memop),
        .MemOpSize  (size),
        .Address_rsp(b_arsp),
        .WData_vld  (wvld & sel),
        .WriteData  (wdata),
        .ReadData   (b_rdata),
        .Data_rsp   (b_drsp),
        .Err        (b_err)
    );

    always_comb begin
        arsp  = sel ? b_arsp  : a_arsp;
        drsp  = sel ? b_drsp  : a_drsp;
        err   = sel ? b_err   : a_err;
        rdata = sel ? b_rdata : a_rdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] mget(input bit s, input int a);
        return s ? mem_b[a] : mem_a[a];
    endfunction

    task automatic mset(input bit s, input int a, input logic [7:0] d);
        if (s) mem_b[a] = d;
        else   mem_a[a] = d;
    endtask

    function automatic bit exp_err(input bit s, input logic [1:0] sz, input logic [31:0] a);
        int depth = s ? 64 : 1024;
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
        if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
        if ((a / 4) >= 32'(depth)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_rd(input bit s, input logic [1:0] sz, input logic [31:0] a);
        int b = int'(a);
        if (exp_err(s, sz, a)) return 32'd0;
        if (sz == 2'd0) return {24'd0, mget(s, b)};
        if (sz == 2'd1) return {16'd0, mget(s, b + 1), mget(s, b)};
        return {mget(s, b + 3), mget(s, b + 2), mget(s, b + 1), mget(s, b)};
    endfunction

    task automatic model_write(input bit s, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int b = int'(a);
        if (exp_err(s, sz, a)) return;
        mset(s, b, d[7:0]);
        if (sz != 2'd0) mset(s, b + 1, d[15:8]);
        if (sz == 2'd2) begin
            mset(s, b + 2, d[23:16]);
            mset(s, b + 3, d[31:24]);
        end
    endtask

    // One complete transaction. Called and returns at a falling edge with
    // the target instance in IDLE.
    task automatic txn(input bit s, input bit op, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input int wdelay);
        int lat = s ? 4 : 1;
        logic        e_err = exp_err(s, sz, a);
        logic [31:0] e_rd;
        sel = s; vld = 1'b1; memop = op; size = sz; addr = a; wvld = 1'b0; wdata = $urandom;
        @(negedge clk);
        check("addr_rsp", {31'd0, arsp}, 32'd1);
        check("drsp_in_ack", {31'd0, drsp}, 32'd0);
        // Request buses become garbage after acceptance.
        vld = 1'($urandom); addr = $urandom; memop = 1'($urandom); size = 2'($urandom);
        if (op) begin
            @(negedge clk);
            for (int k = 0; k < wdelay; k++) begin
                check("wr_stall_drsp", {31'd0, drsp}, 32'd0);
                wdata = $urandom;
                @(negedge clk);
            end
            wvld = 1'b1; wdata = wd;
            @(negedge clk);
            wvld = 1'b0; wdata = $urandom;
            check("wr_drsp", {31'd0, drsp}, 32'd1);
            check("wr_err", {31'd0, err}, {31'd0, e_err});
            model_write(s, sz, a, wd);
        end else begin
            e_rd = exp_rd(s, sz, a);
            for (int k = 1; k < lat; k++) begin
                @(negedge clk);
                check("rd_lat_drsp", {31'd0, drsp}, 32'd0);
                check("rd_lat_rdata", rdata, 32'd0);
            end
            @(negedge clk);
            check("rd_drsp", {31'd0, drsp}, 32'd1);
            check("rd_err", {31'd0, err}, {31'd0, e_err});
            check("rd_data", rdata, e_rd);
        end
        last_rdata = rdata;
        last_err   = err;
        vld = 1'b0;
        @(negedge clk);
        check("post_drsp", {31'd0, drsp}, 32'd0);
        check("post_arsp", {31'd0, arsp}, 32'd0);
        check("post_err",  {31'd0, err},  32'd0);
    endtask

    initial begin
        logic [31:0] a_r;
        logic [1:0]  sz_r;
        bit          s_r;
        rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0; vld = 1'b0; memop = 1'b0;
        size = 2'd0; addr = 32'd0; wvld = 1'b0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_arsp", {31'd0, arsp}, 32'd0);
            check("rst_drsp", {31'd0, drsp}, 32'd0);
            check("rst_err",  {31'd0, err},  32'd0);
            check("rst_rdata", rdata, 32'd0);
        end
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // Directed: first request on the first edge out of reset.
        txn(0, 1, 2'd2, 32'h10, 32'hDEADBEEF, 0);
        txn(0, 0, 2'd2, 32'h10, 32'h0, 0);
        check("word_rd", last_rdata, 32'hDEADBEEF);
        txn(0, 1, 2'd0, 32'h13, 32'h123456A5, 1);
        txn(0, 0, 2'd2, 32'h10, 32'h0, 0);
        check("byte_merge", last_rdata, 32'hA5ADBEEF);
        txn(0, 0, 2'd1, 32'h12, 32'h0, 0);
        check("half_rd", last_rdata, 32'h0000A5AD);
        txn(0, 0, 2'd0, 32'h11, 32'h0, 0);
        check("byte_rd", last_rdata, 32'h000000BE);
        txn(0, 1, 2'd2, 32'h11, 32'hFFFFFFFF, 0);
        check("misalign_err", {31'd0, last_err}, 32'd1);
        txn(0, 0, 2'd2, 32'h10, 32'h0, 0);
        check("misalign_nowr", last_rdata, 32'hA5ADBEEF);
        txn(0, 0, 2'd2, 32'h1000, 32'h0, 0);
        check("oor_err", {31'd0, last_err}, 32'd1);
        check("oor_rdata", last_rdata, 32'd0);

        // Fill both arrays so that every later read has a defined value.
        for (int w = 0; w < 1024; w++) txn(0, 1, 2'd2, 32'(w * 4), $urandom, 0);
        for (int w = 0; w < 64; w++)   txn(1, 1, 2'd2, 32'(w * 4), $urandom, 0);

        // Latency-4 read and a long write stall.
        txn(1, 0, 2'd2, 32'h20, 32'h0, 0);
        txn(1, 1, 2'd1, 32'h22, 32'h0000CAFE, 10);
        txn(1, 0, 2'd2, 32'h20, 32'h0, 0);
        check("stall_wr_hi", {16'd0, last_rdata[31:16]}, 32'h0000CAFE);

        // Reset during WAIT_LAT aborts the read.
        sel = 1'b1; vld = 1'b1; memop = 1'b0; size = 2'd2; addr = 32'h24;
        @(negedge clk);
        check("rl_arsp", {31'd0, arsp}, 32'd1);
        vld = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("rl_no_drsp", {31'd0, drsp}, 32'd0);
            check("rl_no_arsp", {31'd0, arsp}, 32'd0);
            @(negedge clk);
        end
        txn(1, 0, 2'd2, 32'h24, 32'h0, 0);

        // Reset during WAIT_WDATA: no write, and WData_vld in IDLE is ignored.
        sel = 1'b0; vld = 1'b1; memop = 1'b1; size = 2'd2; addr = 32'h40;
        @(negedge clk);
        vld = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0; wvld = 1'b1; wdata = 32'h0BADF00D;
        @(negedge clk);
        check("rw_no_drsp", {31'd0, drsp}, 32'd0);
        wvld = 1'b0;
        txn(0, 0, 2'd2, 32'h40, 32'h0, 0);

        // Randomized traffic on both instances.
        for (int i = 0; i < 600; i++) begin
            s_r  = 1'($urandom);
            sz_r = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
            if ($urandom % 8 == 0) a_r = $urandom;
            else                   a_r = $urandom % (s_r ? 256 : 4096);
            txn(s_r, 1'($urandom), sz_r, a_r, $urandom, int'($urandom % 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv_dmem_responder.md
RV_DMEM_RESPONDER -- requirements
Module: rv_dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words in the array, power of two.
REQ-002 SHALL have parameter LATENCY, default 1: cycles from the Address_rsp cycle to the read Data_rsp cycle, legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port Address_vld  input  1  initiator request valid.
REQ-006 SHALL have port Address  input  32  byte address.
REQ-007 SHALL have port MemOp  input  1  0 = read, 1 = write.
REQ-008 SHALL have port MemOpSize  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-009 SHALL have port Address_rsp  output  1  request accepted, one-cycle pulse.
REQ-010 SHALL have port WData_vld  input  1  write data valid.
REQ-011 SHALL have port WriteData  input  32  write data, LSB-justified.
REQ-012 SHALL have port ReadData  output  32  read data, right-justified, zero-extended.
REQ-013 SHALL have port Data_rsp  output  1  data phase complete, one-cycle pulse.
REQ-014 SHALL have port Err  output  1  access error, valid only while Data_rsp is high.

Function
REQ-015 SHALL implement the FSM states IDLE, ACK, WAIT_WDATA, WAIT_LAT and RESP.
REQ-016 SHALL sample Address_vld only in IDLE.
REQ-017 In IDLE with Address_vld=1, SHALL capture Address, MemOp and MemOpSize, then go to ACK.
REQ-018 In ACK, SHALL assert Address_rsp=1 for exactly one cycle.
REQ-019 After ACK, SHALL go to WAIT_WDATA for a write and to WAIT_LAT for a read.
REQ-020 SHALL sample WData_vld only in WAIT_WDATA and ignore it in all other states.
REQ-021 In WAIT_WDATA, SHALL wait with no timeout until WData_vld=1, then on that edge commit the write (if legal) and go to RESP.
REQ-022 SHALL count LATENCY-1 cycles in WAIT_LAT, then go to RESP, so read Data_rsp rises exactly LATENCY cycles after the Address_rsp cycle.
REQ-023 SHALL take the read array data from the captured word index.
REQ-024 In RESP, SHALL assert Data_rsp=1 for exactly one cycle and drive ReadData and Err.
REQ-025 After RESP, SHALL return to IDLE, so back-to-back requests are accepted no sooner than the cycle after RESP.
REQ-026 Write lane placement SHALL be:
- byte: WriteData[7:0] to lane Address[1:0].
- half: WriteData[15:0] to lanes {Address[1],0}+1..0.
- word: all lanes.
- Non-selected bytes unchanged.
REQ-027 Read extraction SHALL be:
- byte: selected lane zero-extended.
- half: selected halfword zero-extended.
- word: full word.
REQ-028 Err=1 SHALL result from any of:
- MemOpSize=3.
- half with Address[0]=1.
- word with Address[1:0]!=0.
- Address[31:2] >= DEPTH_WORDS (no address wrap).
REQ-029 On an Err write, SHALL leave the array unchanged.
REQ-030 On an Err read, SHALL return ReadData=0.
REQ-031 An Err transaction SHALL still complete the full handshake with normal timing.
REQ-032 Outside RESP, SHALL drive ReadData=0 and Err=0.
REQ-033 Request inputs changing after acceptance SHALL have no effect, because captured values are used.

Reset
REQ-034 While rst=1 at a rising edge, SHALL go to IDLE with Address_rsp=0, Data_rsp=0, Err=0, ReadData=0 and the latency counter at 0.
REQ-035 Reset mid-transaction SHALL abort it with no Data_rsp, and no array write unless the commit edge already occurred.
REQ-036 Reset SHALL NOT clear array contents.
REQ-037 The first request SHALL be sampled on the first edge with rst=0.

Verification
REQ-038 Word write then read, LATENCY=1:
- Stimulus: write 0x10, data 0xDEADBEEF; then read word 0x10.
- Response: Address_rsp at cycle N+1; read Data_rsp at N'+2 with ReadData=0xDEADBEEF, Err=0.
REQ-039 Byte write, merged read: after REQ-038, write byte 0xA5 to 0x13; read word 0x10 -> 0xA5ADBEEF.
REQ-040 Half read: after REQ-039, read half 0x12 -> 0x0000A5AD; read byte 0x11 -> 0x000000BE.
REQ-041 Misaligned and out-of-range accesses:
- Word write to 0x11 -> Data_rsp with Err=1, and read word 0x10 still 0xA5ADBEEF.
- Read at 0x1000 with DEPTH_WORDS=1024 -> Err=1, ReadData=0.
REQ-042 Latency and write stall: LATENCY=4 read -> Data_rsp exactly 4 cycles after Address_rsp; WData_vld withheld 10 cycles -> Data_rsp the cycle after WData_vld is sampled.
REQ-043 Reset in WAIT_LAT: no Data_rsp; FSM in IDLE; next request accepted normally.
